// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: key codes, ALU op codes,
// display-select codes, FSM state encoding and key classification helpers.
// No logic, no latency, no flow control.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_DIV = 4'd13;
    localparam logic [3:0] KEY_EQ  = 4'd14;
    localparam logic [3:0] KEY_CLR = 4'd15;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_MUL = 2'd2;
    localparam logic [1:0] ALU_DIV = 2'd3;

    localparam logic [1:0] DISP_NUM1   = 2'd0;
    localparam logic [1:0] DISP_NUM2   = 2'd1;
    localparam logic [1:0] DISP_RESULT = 2'd2;
    localparam logic [1:0] DISP_ERROR  = 2'd3;

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_ENTER_B = 3'd1,
        ST_EXEC    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_SHOW    = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

    function automatic logic key_is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic key_is_op(input logic [3:0] k);
        return (k >= KEY_ADD) && (k <= KEY_DIV);
    endfunction

    function automatic logic [1:0] key_to_op(input logic [3:0] k);
        logic [1:0] op;
        case (k)
            KEY_SUB: op = ALU_SUB;
            KEY_MUL: op = ALU_MUL;
            KEY_DIV: op = ALU_DIV;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/calc_operand_acc.sv
// Decimal operand accumulator: value register plus digit count.
// Latency: every operation takes effect at the next rising edge.
// Backpressure: none; the caller decides when an operation is applied.
// Ports: clk/rst (sync, active-low); clr zeroes value and count; load_val
// loads val_dat/cnt_dat; load_digit loads a single digit with count 1;
// append shifts in a digit unless MAX_DIGITS are already held; val/cnt out.
module calc_operand_acc #(
    parameter int W          = 16,
    parameter int MAX_DIGITS = 4,
    parameter int CW         = $clog2(MAX_DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load_val,
    input  logic [W-1:0]  val_dat,
    input  logic [CW-1:0] cnt_dat,
    input  logic          load_digit,
    input  logic          append,
    input  logic [3:0]    digit,
    output logic [W-1:0]  val,
    output logic [CW-1:0] cnt
);

    logic [W-1:0] digit_w;
    assign digit_w = W'(digit);

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            val <= '0;
            cnt <= '0;
        end else if (load_val) begin
            val <= val_dat;
            cnt <= cnt_dat;
        end else if (load_digit) begin
            val <= digit_w;
            cnt <= CW'(1);
        end else if (append && (cnt < CW'(MAX_DIGITS))) begin
            // W is sized so MAX_DIGITS decimal digits never overflow.
            val <= val * W'(10) + digit_w;
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: builds two decimal operands from keys, issues one ALU op, shows result.
// Latency: key at edge N visible in cycle N+1; eq -> alu_start next cycle; alu_done -> result next cycle.
// Backpressure: key_ready is low while an ALU op is in flight (EXEC/WAIT); keys are held off.
// Ports: key_valid/key_code/key_ready keypad handshake; alu_start/alu_op/alu_a/alu_b
// issue side; alu_done/alu_result/alu_err completion; disp_value/disp_sel display; busy.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int W          = 16,
    parameter int MAX_DIGITS = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    output logic         key_ready,
    output logic         alu_start,
    output logic [1:0]   alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic         alu_done,
    input  logic [W-1:0] alu_result,
    input  logic         alu_err,
    output logic [W-1:0] disp_value,
    output logic [1:0]   disp_sel,
    output logic         busy
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [W-1:0]  res;
    logic [1:0]    op;
    logic [TW-1:0] tmo_cnt;

    logic          key_acc;
    logic          k_digit, k_op, k_eq, k_clr;
    logic          a_clr, a_load_val, a_load_digit, a_append;
    logic          b_clr, b_append;
    logic [W-1:0]  a_val, b_val;
    logic [CW-1:0] a_cnt_unused, b_cnt;

    assign busy      = (state == ST_EXEC) || (state == ST_WAIT);
    assign key_ready = !busy;
    assign key_acc   = key_valid && key_ready;

    assign k_digit = key_is_digit(key_code);
    assign k_op    = key_is_op(key_code);
    assign k_eq    = (key_code == KEY_EQ);
    assign k_clr   = (key_code == KEY_CLR);

    // Clear wins in every key-accepting state, so it only needs key_acc.
    assign a_clr        = key_acc && k_clr;
    assign a_load_val   = key_acc && k_op    && (state == ST_SHOW);
    assign a_load_digit = key_acc && k_digit && (state == ST_SHOW);
    assign a_append     = key_acc && k_digit && (state == ST_ENTER_A);
    assign b_clr        = a_clr || (key_acc && k_op &&
                          ((state == ST_ENTER_A) || (state == ST_SHOW)));
    assign b_append     = key_acc && k_digit && (state == ST_ENTER_B);

    // Chaining from a result: A takes the result with a full count so no
    // further digits can be appended to it.
    calc_operand_acc #(.W(W), .MAX_DIGITS(MAX_DIGITS)) u_acc_a (
        .clk        (clk),
        .rst        (rst),
        .clr        (a_clr),
        .load_val   (a_load_val),
        .val_dat    (res),
        .cnt_dat    (CW'(MAX_DIGITS)),
        .load_digit (a_load_digit),
        .append     (a_append),
        .digit      (key_code),
        .val        (a_val),
        .cnt        (a_cnt_unused)
    );

    calc_operand_acc #(.W(W), .MAX_DIGITS(MAX_DIGITS)) u_acc_b (
        .clk        (clk),
        .rst        (rst),
        .clr        (b_clr),
        .load_val   (1'b0),
        .val_dat    ('0),
        .cnt_dat    ('0),
        .load_digit (1'b0),
        .append     (b_append),
        .digit      (key_code),
        .val        (b_val),
        .cnt        (b_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_ENTER_A;
            res       <= '0;
            op        <= ALU_ADD;
            tmo_cnt   <= '0;
            alu_start <= 1'b0;
            alu_op    <= ALU_ADD;
            alu_a     <= '0;
            alu_b     <= '0;
        end else begin
            alu_start <= 1'b0;
            if (a_clr) begin
                state <= ST_ENTER_A;
                res   <= '0;
                op    <= ALU_ADD;
            end else begin
                case (state)
                    ST_ENTER_A: begin
                        if (key_acc && k_op) begin
                            op    <= key_to_op(key_code);
                            state <= ST_ENTER_B;
                        end
                    end
                    ST_ENTER_B: begin
                        if (key_acc && k_op && (b_cnt == '0)) begin
                            op <= key_to_op(key_code);
                        end else if (key_acc && k_eq && (b_cnt != '0)) begin
                            // Operands are captured here and held until the
                            // next issue, covering the whole EXEC/WAIT window.
                            state     <= ST_EXEC;
                            alu_start <= 1'b1;
                            alu_a     <= a_val;
                            alu_b     <= b_val;
                            alu_op    <= op;
                        end
                    end
                    ST_EXEC: begin
                        state   <= ST_WAIT;
                        tmo_cnt <= '0;
                    end
                    ST_WAIT: begin
                        if (alu_done) begin
                            res   <= alu_result;
                            state <= alu_err ? ST_ERROR : ST_SHOW;
                        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                            // This is the TIMEOUT-th WAIT cycle without done.
                            state <= ST_ERROR;
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end
                    ST_SHOW: begin
                        if (key_acc && k_digit) begin
                            state <= ST_ENTER_A;
                        end else if (key_acc && k_op) begin
                            op    <= key_to_op(key_code);
                            state <= ST_ENTER_B;
                        end
                    end
                    ST_ERROR: begin
                    end
                    default: state <= ST_ENTER_A;
                endcase
            end
        end
    end

    always_comb begin
        disp_value = '0;
        disp_sel   = DISP_NUM1;
        case (state)
            ST_ENTER_A: begin
                disp_value = a_val;
                disp_sel   = DISP_NUM1;
            end
            ST_ENTER_B, ST_EXEC, ST_WAIT: begin
                disp_value = b_val;
                disp_sel   = DISP_NUM2;
            end
            ST_SHOW: begin
                disp_value = res;
                disp_sel   = DISP_RESULT;
            end
            ST_ERROR: begin
                disp_value = '0;
                disp_sel   = DISP_ERROR;
            end
            default: begin
                disp_value = '0;
                disp_sel   = DISP_NUM1;
            end
        endcase
    end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Sequencing controller for the calculator datapath. It consumes keypad events and builds two decimal operands. It then issues one operation to the ALU, waits for completion, and drives a display-select code equivalent to the existing three-phase calculator FSM (num1 / num2 / result), extended with an error phase. It sits between the key decoder and the ALU/display mux.

## Interface
- `W`, 16, operand/result width in bits; must satisfy 2^W > 10^MAX_DIGITS − 1
- `MAX_DIGITS`, 4, maximum decimal digits per operand
- `TIMEOUT`, 255, maximum cycles spent waiting for `alu_done` before entering error

- `clk` in 1, single clock; all logic on rising edge
- `rst` in 1, synchronous, active-low reset
- `key_valid` in 1, key event present
- `key_code` in 4, key code: 0–9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 eq, 15 clear
- `key_ready` out 1, event accepted on a cycle where `key_valid && key_ready`
- `alu_start` out 1, one-cycle start pulse
- `alu_op` out 2, operation: 0 add, 1 sub, 2 mul, 3 div
- `alu_a` out W, operand A
- `alu_b` out W, operand B
- `alu_done` in 1, ALU result valid (one-cycle pulse)
- `alu_result` in W, ALU result
- `alu_err` in 1, ALU error, qualified by `alu_done`
- `disp_value` out W, value to display
- `disp_sel` out 2, display phase: 0 num1, 1 num2, 2 result, 3 error
- `busy` out 1, high in EXEC and WAIT

## Operation
States: ENTER_A, ENTER_B, EXEC, WAIT, SHOW, ERROR. Reset enters ENTER_A.

- **ENTER_A**
  - Digit: if `cnt_a < MAX_DIGITS`, then `a ← a*10 + d` and `cnt_a++`; otherwise the digit is dropped.
  - Op: latch the op, clear `b` and `cnt_b`, go to ENTER_B.
  - Eq: ignored.
- **ENTER_B**
  - Digit: same rule as ENTER_A, applied to `b`.
  - Op: if `cnt_b == 0`, replace the latched op; otherwise ignored.
  - Eq: if `cnt_b > 0`, go to EXEC; otherwise ignored.
- **EXEC**: `alu_start = 1` for exactly this cycle, then go to WAIT.
- **WAIT**
  - On `alu_done`: latch `alu_result` into `res`; go to ERROR if `alu_err`, else SHOW.
  - The timeout counter saturating at TIMEOUT → ERROR.
- **SHOW**
  - Digit: `a ← d`, `cnt_a = 1`, go to ENTER_A.
  - Op: `a ← res`, `cnt_a = MAX_DIGITS` (so digit entry is frozen), latch the op, clear `b`, go to ENTER_B.
  - Eq: ignored.
- **ERROR**: only clear is accepted; all other keys are consumed and dropped.
- **Clear**: accepted in ENTER_A, ENTER_B, SHOW and ERROR. It zeroes `a`, `b`, `res`, both counts and the op, then goes to ENTER_A.
- **`key_ready`**: 0 in EXEC and WAIT, 1 otherwise.
- **`alu_done` outside WAIT** (including after a mid-operation reset): ignored.
- **Display**
  - ENTER_A: `disp_value = a`, `disp_sel = 0`
  - ENTER_B: `disp_value = b`, `disp_sel = 1`
  - EXEC/WAIT: `disp_value = b`, `disp_sel = 1`
  - SHOW: `disp_value = res`, `disp_sel = 2`
  - ERROR: `disp_value = 0`, `disp_sel = 3`
- **Arithmetic**: the accumulator multiply-add is unsigned at W bits; there is no overflow, given the W constraint above.

## Timing
- **Reset values**: state ENTER_A; all registers 0; `alu_start = 0`, `alu_op = 0`, `alu_a = alu_b = 0`, `disp_value = 0`, `disp_sel = 0`, `busy = 0`, `key_ready = 1`.
- **Key acceptance**: a key accepted at edge N is reflected in state, registers and display after edge N (visible in cycle N+1).
- **Start latency**: eq accepted in cycle N → EXEC in cycle N+1 (`alu_start` high) → WAIT from N+2.
- **ALU operand hold**: `alu_a`, `alu_b` and `alu_op` are registered outputs. They are stable from EXEC until the cycle after `alu_done` is sampled.
- **`alu_done` sampling**: sampled only in WAIT. The earliest legal response is the cycle after `alu_start`.
- **Completion latency**: `alu_done` in cycle M → SHOW/ERROR and `res` visible in cycle M+1.
- **Timeout**: the counter clears on WAIT entry. ERROR is entered on the TIMEOUT-th WAIT cycle without `alu_done`.
- **Reset priority**: reset asserted in any state, including mid-WAIT, overrides all inputs that cycle. `alu_start` is never asserted in the cycle after reset is applied.

## Structure
- **Package `calc_pkg`**:
  - key-code constants (KEY_ADD … KEY_CLR, KEY_EQ)
  - ALU op codes
  - `disp_sel` codes
  - state encoding
- **Sub-module `calc_operand_acc`**: one instance each for A and B. It holds the value and digit count, and supports these ops:
  - load-digit
  - load-value (with count)
  - append-digit with MAX_DIGITS saturation
  - clear

## Test plan
- **Basic add**: keys 1,2,add,3,4,eq; ALU returns 46 four cycles after start → `alu_a = 12`, `alu_b = 34`, `alu_op = 0`, single `alu_start` pulse; then SHOW, `disp_value = 46`, `disp_sel = 2`.
- **Digit saturation**: keys 9,8,7,6,5 → `a = 9876`, fifth digit dropped. A following op with no digits then eq → eq ignored, state stays ENTER_B.
- **Chaining**: from SHOW with `res = 46`, keys sub,6,eq → `alu_a = 46`, `alu_b = 6`, `alu_op = 1`. A digit 7 from SHOW instead → `a = 7`, `disp_sel = 0`.
- **ALU error path**: div with b = 0; ALU returns done + err → ERROR, `disp_sel = 3`. Digits are ignored; clear → ENTER_A, `disp_value = 0`.
- **Timeout and handshake**: eq then no `alu_done` → `key_ready = 0` and `busy = 1` throughout; ERROR after exactly 255 WAIT cycles. A late `alu_done` is ignored.
- **Reset mid-WAIT**: `rst = 0` during WAIT; `alu_done` arrives on the next cycle → all outputs at reset values, ENTER_A, no result latched.
